// File: rtl/life_pkg.sv
// Shared types for the cellular-grid simulator run control and its status display.
package life_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEED  = 3'd1,
        PAUSE = 3'd2,
        RUN   = 3'd3,
        STEP  = 3'd4,
        DONE  = 3'd5
    } run_state_t;

endpackage

// File: rtl/rate_divider.sv
// Up-counting rate divider: counts 0..max(rate,1)-1 and registers a one-cycle tick
// on terminal count. A synchronous clear zeroes both the count and a pending tick.
module rate_divider #(
    parameter int RATE_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic [RATE_W-1:0] rate_i,
    output logic              tick_o
);

    logic [RATE_W-1:0] cnt_q, cnt_d;
    logic [RATE_W-1:0] term;
    logic              tick_q, tick_d;

    // Compare with >= so that lowering the rate below the current count ticks at once.
    always_comb begin
        term   = (rate_i == '0) ? '0 : rate_i - RATE_W'(1);
        cnt_d  = cnt_q + RATE_W'(1);
        tick_d = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q >= term) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/life_run_ctrl.sv
// Run controller for the cellular-grid simulator: LFSR seeding, free-run, pause,
// single-step, programmable generation rate and optional generation limit.
module life_run_ctrl
    import life_pkg::*;
#(
    parameter int SEED_CYCLES = 16,
    parameter int GEN_W       = 16,
    parameter int RATE_W      = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              step,
    input  logic              seed_req,
    input  logic [RATE_W-1:0] rate,
    input  logic [GEN_W-1:0]  max_gens,
    output logic              lfsr_reset,
    output logic              lfsr_en,
    output logic              grid_rst,
    output logic              en,
    output logic [GEN_W-1:0]  gen_count,
    output logic              busy,
    output logic              done
);

    localparam int SEED_W = (SEED_CYCLES > 1) ? $clog2(SEED_CYCLES) : 1;
    localparam logic [SEED_W-1:0] SEED_LAST = SEED_W'(SEED_CYCLES - 1);

    run_state_t        state_q, state_d;
    logic [SEED_W-1:0] seed_cnt_q, seed_cnt_d;
    logic [GEN_W-1:0]  gen_q, gen_d;
    logic              div_clr;
    logic              div_tick;
    logic              gen_inc;
    logic              limit_hit;

    rate_divider #(.RATE_W(RATE_W)) u_div (
        .clk    (clk),
        .rst_n  (reset),
        .clr_i  (div_clr),
        .rate_i (rate),
        .tick_o (div_tick)
    );

    // A generation completes exactly on the cycles where en is visible.
    assign gen_inc   = ((state_q == RUN) && div_tick) || (state_q == STEP);
    assign limit_hit = gen_inc && (max_gens != '0) && ((gen_q + GEN_W'(1)) == max_gens);
    assign div_clr   = !((state_q == RUN) && (state_d == RUN));

    always_comb begin
        state_d    = state_q;
        seed_cnt_d = '0;
        gen_d      = gen_q;
        if (gen_inc) gen_d = gen_q + GEN_W'(1);

        case (state_q)
            IDLE: begin
                if (!stop) begin
                    if (seed_req)   state_d = SEED;
                    else if (start) state_d = RUN;
                end
            end
            SEED: begin
                if (stop)                         state_d = IDLE;
                else if (seed_cnt_q == SEED_LAST) state_d = PAUSE;
                else                              seed_cnt_d = seed_cnt_q + SEED_W'(1);
            end
            PAUSE: begin
                if (stop)          state_d = IDLE;
                else if (seed_req) state_d = SEED;
                else if (start)    state_d = RUN;
                else if (step)     state_d = STEP;
            end
            RUN: begin
                if (stop)           state_d = PAUSE;
                else if (seed_req)  state_d = SEED;
                else if (limit_hit) state_d = DONE;
            end
            STEP: begin
                state_d = limit_hit ? DONE : PAUSE;
            end
            DONE: begin
                if (stop)          state_d = IDLE;
                else if (seed_req) state_d = SEED;
                else if (start) begin
                    state_d = RUN;
                    gen_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if ((state_d == IDLE) || ((state_d == SEED) && (state_q != SEED))) gen_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            seed_cnt_q <= '0;
            gen_q      <= '0;
        end else begin
            state_q    <= state_d;
            seed_cnt_q <= seed_cnt_d;
            gen_q      <= gen_d;
        end
    end

    always_comb begin
        lfsr_reset = 1'b0;
        lfsr_en    = 1'b0;
        grid_rst   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                lfsr_reset = 1'b1;
                grid_rst   = 1'b1;
            end
            SEED: begin
                lfsr_en  = 1'b1;
                grid_rst = 1'b1;
                busy     = 1'b1;
            end
            RUN, STEP: busy = 1'b1;
            DONE:      done = 1'b1;
            default: ;
        endcase
    end

    assign en        = gen_inc;
    assign gen_count = gen_q;

endmodule

// File: tb/tb_life_run_ctrl.sv
// Directed bench for life_run_ctrl with hand-computed expected values.
module tb_life_run_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, stop, step, seed_req;
    logic [23:0] rate;
    logic [15:0] max_gens;
    logic        lfsr_reset, lfsr_en, grid_rst, en, busy, done;
    logic [15:0] gen_count;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    life_run_ctrl #(.SEED_CYCLES(16), .GEN_W(16), .RATE_W(24)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .step       (step),
        .seed_req   (seed_req),
        .rate       (rate),
        .max_gens   (max_gens),
        .lfsr_reset (lfsr_reset),
        .lfsr_en    (lfsr_en),
        .grid_rst   (grid_rst),
        .en         (en),
        .gen_count  (gen_count),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [12:0] en_vec;
        logic [7:0]  en_v5, done_v5;
        int          cnt;

        reset = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0; seed_req = 1'b0;
        rate = 24'd4; max_gens = 16'd0;

        // 1: reset values
        repeat (3) cyc();
        chk("rst_lfsr_reset", 32'(lfsr_reset), 32'd1);
        chk("rst_grid_rst",   32'(grid_rst),   32'd1);
        chk("rst_en",         32'(en),         32'd0);
        chk("rst_lfsr_en",    32'(lfsr_en),    32'd0);
        chk("rst_busy",       32'(busy),       32'd0);
        chk("rst_done",       32'(done),       32'd0);
        chk("rst_gen",        32'(gen_count),  32'd0);
        reset = 1'b1;
        cyc();
        chk("idle_lfsr_reset", 32'(lfsr_reset), 32'd1);
        step = 1'b1; cyc(); step = 1'b0;
        chk("idle_step_busy", 32'(busy), 32'd0);
        chk("idle_step_en",   32'(en),   32'd0);

        // 2: seed_req beats start in the same cycle; lfsr_en high 16 cycles
        seed_req = 1'b1; start = 1'b1; cyc(); seed_req = 1'b0; start = 1'b0;
        chk("seed_busy", 32'(busy), 32'd1);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (lfsr_en) cnt++;
            cyc();
        end
        chk("seed_len",        32'(cnt),        32'd16);
        chk("seed_pause_busy", 32'(busy),       32'd0);
        chk("seed_pause_grid", 32'(grid_rst),   32'd0);
        chk("seed_pause_lrst", 32'(lfsr_reset), 32'd0);

        // 3: rate 4, en every 4th cycle, first at cycle 4 after entry
        rate = 24'd4;
        start = 1'b1; cyc(); start = 1'b0;
        for (int k = 0; k < 13; k++) begin
            en_vec[k] = en;
            cyc();
        end
        chk("run4_en_pattern", 32'(en_vec), 32'h1110);
        chk("run4_gen",        32'(gen_count), 32'd3);
        chk("run4_busy",       32'(busy), 32'd1);
        stop = 1'b1; cyc(); stop = 1'b0;
        chk("run_stop_gen",  32'(gen_count), 32'd3);
        chk("run_stop_busy", 32'(busy), 32'd0);
        stop = 1'b1; cyc(); stop = 1'b0;
        chk("pause_stop_gen",  32'(gen_count),  32'd0);
        chk("pause_stop_lrst", 32'(lfsr_reset), 32'd1);
        seed_req = 1'b1; cyc(); seed_req = 1'b0;
        repeat (20) cyc();

        // 4: three single steps
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step = 1'b1; cyc(); step = 1'b0;
            for (int j = 0; j < 5; j++) begin
                if (en) cnt++;
                cyc();
            end
            chk("step_gen", 32'(gen_count), 32'(i + 1));
        end
        chk("step_en_count", 32'(cnt), 32'd3);
        chk("step_busy",     32'(busy), 32'd0);

        // 5: limit of 5 at rate 1
        stop = 1'b1; cyc(); stop = 1'b0;
        rate = 24'd1; max_gens = 16'd5;
        start = 1'b1; cyc(); start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            en_v5[k]   = en;
            done_v5[k] = done;
            cyc();
        end
        chk("lim_en_pattern",   32'(en_v5),   32'h3E);
        chk("lim_done_pattern", 32'(done_v5), 32'hC0);
        chk("lim_gen",          32'(gen_count), 32'd5);
        chk("lim_busy",         32'(busy), 32'd0);
        start = 1'b1; cyc(); start = 1'b0;
        chk("restart_gen",  32'(gen_count), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_done", 32'(done), 32'd0);

        // 6: stop at terminal count suppresses en
        stop = 1'b1; cyc(); stop = 1'b0;
        chk("stop_tc1_en",  32'(en), 32'd0);
        chk("stop_tc1_gen", 32'(gen_count), 32'd0);
        max_gens = 16'd0; rate = 24'd4;
        start = 1'b1; cyc(); start = 1'b0;
        repeat (3) cyc();
        stop = 1'b1; start = 1'b1; cyc(); stop = 1'b0; start = 1'b0;
        chk("stop_tc4_en",   32'(en), 32'd0);
        chk("stop_tc4_busy", 32'(busy), 32'd0);
        chk("stop_tc4_gen",  32'(gen_count), 32'd0);
        cyc();
        chk("stop_tc4_en2", 32'(en), 32'd0);

        // reset mid-RUN
        start = 1'b1; cyc(); start = 1'b0;
        repeat (6) cyc();
        chk("midrun_gen", 32'(gen_count), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst_en",   32'(en), 32'd0);
        chk("arst_gen",  32'(gen_count), 32'd0);
        chk("arst_lrst", 32'(lfsr_reset), 32'd1);
        chk("arst_grid", 32'(grid_rst), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        cyc();
        reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (en || busy) cnt++;
        end
        chk("post_rst_idle", 32'(cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
